// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multiport register file and its
// scrub sequencer.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 16;
  localparam int REGFILE_ADDR_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } scrub_state_e;

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// Scrub sequencer: walks every register index once, supplying the write-port
// override (select, index, latched value) and the busy / scrub_done flags.
module regfile_scrub_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_req_i,
  input  logic [DATA_W-1:0] scrub_val_i,
  output logic              scrub_sel_o,
  output logic [ADDR_W-1:0] scrub_idx_o,
  output logic [DATA_W-1:0] scrub_val_o,
  output logic              busy_o,
  output logic              scrub_done_o,
  output scrub_state_e      state_o
);

  // All-ones is NREGS-1; the index may wrap, but termination never relies on it.
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    case (state_q)
      IDLE: begin
        if (scrub_req_i) begin
          state_d = SCRUB;
          idx_d   = '0;
          val_d   = scrub_val_i;
        end
      end
      SCRUB: begin
        // scrub_req_i is deliberately not looked at here: no restart.
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d == SCRUB);
    done_d = (state_d == SCRUB) && (idx_d == LAST_IDX);
  end

  always_comb begin
    scrub_sel_o  = (state_q == SCRUB);
    scrub_idx_o  = idx_q;
    scrub_val_o  = val_q;
    busy_o       = busy_q;
    scrub_done_o = done_q;
    state_o      = state_q;
  end

endmodule

// File: rtl/multiport_regfile.sv
// Register file with one write port, two registered read ports with
// write-to-read bypass, and a scrub sequencer that rewrites every register.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              scrub_req,
  input  logic [DATA_W-1:0] scrub_val,
  output logic              busy,
  output logic              scrub_done
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;

  logic              scrub_sel;
  logic [ADDR_W-1:0] scrub_idx;
  logic [DATA_W-1:0] scrub_wval;
  scrub_state_e      scrub_state;

  logic              we_i;
  logic [ADDR_W-1:0] wa_i;
  logic [DATA_W-1:0] wd_i;

  regfile_scrub_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_scrub_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .scrub_req_i (scrub_req),
    .scrub_val_i (scrub_val),
    .scrub_sel_o (scrub_sel),
    .scrub_idx_o (scrub_idx),
    .scrub_val_o (scrub_wval),
    .busy_o      (busy),
    .scrub_done_o(scrub_done),
    .state_o     (scrub_state)
  );

  // While scrubbing the external write is dropped, not queued.
  always_comb begin
    we_i = write;
    wa_i = writenum;
    wd_i = data_in;
    if (scrub_sel) begin
      we_i = 1'b1;
      wa_i = scrub_idx;
      wd_i = scrub_wval;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Bypass lets a read in the same cycle as a write return the new data.
  always_comb begin
    rd_a_d = (we_i && (wa_i == readnum_a)) ? wd_i : mem_q[readnum_a];
    rd_b_d = (we_i && (wa_i == readnum_b)) ? wd_i : mem_q[readnum_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign data_out_a = rd_a_q;
  assign data_out_b = rd_b_q;

endmodule
